accumulator_x16: RTL and testbench
==================================

Name: accumulator_x16

Overview:
- Downstream consumer of the 16-bit adder datapath in the MAC lane.
- Accepts a stream of signed 16-bit partial sums/products framed by a last flag, and accumulates each frame into a saturating signed 16-bit result.
- Presents the result, an overflow flag and a term count to the activation stage over a valid/ready handshake.

Parameters:
- WIDTH, 16, data and accumulator width (two's complement).
- COUNT_WIDTH, 8, width of the per-frame term counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort of the current frame; drops partial accumulation.
- inValid  input  1  upstream data valid.
- inReady  output  1  block can accept a beat.
- inData  input  WIDTH  signed term to accumulate.
- inLast  input  1  qualifies the final term of a frame.
- outValid  output  1  result available.
- outReady  input  1  downstream accepts the result.
- outData  output  WIDTH  saturated signed frame sum.
- outOverflow  output  1  saturation occurred at least once in the frame.
- outCount  output  COUNT_WIDTH  number of terms in the frame (saturating).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - State ACCUM; accumulator = 0; overflow = 0; count = 0; first = 1.
  - outValid = 0; outData = 0; outOverflow = 0; outCount = 0; inReady = 1 after reset deasserts.
- States: ACCUM, HOLD.
- ACCUM:
  - inReady = 1; outValid = 0.
  - A beat is accepted when inValid && inReady.
  - On an accepted beat with first = 1: acc <= inData; overflow <= 0; count <= 1; first <= 0.
  - On an accepted beat with first = 0: acc <= satadd(acc, inData); overflow <= overflow | sat; count <= count + 1, saturating at 2^COUNT_WIDTH - 1.
  - On an accepted beat with inLast = 1: the beat is accumulated as above, then the next state is HOLD. Result registers take the post-beat acc, overflow and count the same edge.
  - A single-beat frame (first && last) gives outData = inData, outCount = 1, outOverflow = 0.
- HOLD:
  - inReady = 0; outValid = 1; outData, outOverflow and outCount are stable until accepted.
  - When outReady = 1: next state is ACCUM; first <= 1; acc, overflow and count cleared.
  - Output is registered. outValid rises the cycle after the last-beat handshake.
  - Throughput is one beat per cycle within a frame, plus one bubble cycle per frame minimum.
- satadd:
  - Compute a full WIDTH+1-bit signed sum.
  - If it exceeds 2^(WIDTH-1) - 1, clamp to 0x7FFF and set sat.
  - If it is below -2^(WIDTH-1), clamp to 0x8000 and set sat.
  - Saturation is sticky: once clamped, later terms continue from the clamped value.
- clear:
  - In ACCUM: discards the partial frame and forces first = 1, acc = 0, count = 0. Any beat presented in the same cycle is dropped, and inReady remains 1.
  - In HOLD: ignored. A pending result is never lost.
- reset dominates clear and all handshakes. Reset mid-frame or in HOLD returns the block to the reset values the next edge.
- inLast is ignored when there is no handshake.
- outReady is ignored when outValid = 0.

Decomposition:
- Shared package mac_pkg:
  - WIDTH_DEFAULT constant.
  - SAT_MAX = 16'sh7FFF and SAT_MIN = 16'sh8000 constants.
  - State enum acc_state_t {ACCUM, HOLD}.
- One natural sub-module: sat_add16.
  - Combinational: a, b in; sum and sat out.
  - Instantiated once, so the saturation logic can be verified standalone.

Test Plan:
- Reset then frame {3, 4, -2 last}, outReady = 1 → outValid rises the cycle after the last beat; outData = 5, outCount = 3, outOverflow = 0, outValid held 1 cycle.
- Frame {0x7000, 0x2000, -0x1000 last} → 0x7FFF after beat 2, then 0x6FFF; outData = 0x6FFF, outOverflow = 1.
- Frame {0x8001, -5 last} → outData = 0x8000, outOverflow = 1. Single-beat frame {-7 last} → outData = 0xFFF9, outCount = 1.
- Hold outReady = 0 for 5 cycles with inValid = 1 → inReady = 0, outputs stable, no beats consumed. Then outReady = 1 → next frame starts from acc = 0.
- Frame {10, 20}, then clear with inValid = 1, data 99, then {1 last} → outData = 1, outCount = 1. Clear pulsed in HOLD leaves the pending result intact.
- 300-beat frame of +0 with last → outCount = 255 (saturated). Reset asserted mid-frame → outValid = 0, inReady = 1, and the next 1-beat frame reports outCount = 1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC lane datapath blocks.
//   WIDTH_DEFAULT : default data/accumulator width.
//   SAT_MAX/MIN   : saturation clamp values for the 16-bit signed datapath.
//   acc_state_t   : accumulator control states.
package mac_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage : mac_pkg

// File: rtl/sat_add16.sv
// Combinational saturating signed adder.
//   i_a, i_b : signed WIDTH-bit operands
//   o_sum    : signed sum clamped to the WIDTH-bit signed range
//   o_sat    : high when the sum was clamped
module sat_add16
  import mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_sum,
  output logic                    o_sat
);

  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH:0] w_full;

  // One extra bit of headroom: the two top bits disagree exactly on overflow.
  assign w_full = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

  always_comb begin
    o_sum = w_full[WIDTH-1:0];
    o_sat = 1'b0;
    if (w_full[WIDTH] != w_full[WIDTH-1]) begin
      o_sat = 1'b1;
      o_sum = w_full[WIDTH] ? W_MIN : W_MAX;
    end
  end

endmodule : sat_add16

// File: rtl/accumulator_x16.sv
// Frame accumulator: sums a last-framed stream of signed terms into a
// saturating signed result and hands it downstream over valid/ready.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : abort the partial frame (ignored while a result is held)
//   inValid/inReady/inData/inLast : input beat stream
//   outValid/outReady             : result handshake
//   outData      : saturated frame sum
//   outOverflow  : saturation occurred somewhere in the frame
//   outCount     : number of terms in the frame (saturating)
module accumulator_x16
  import mac_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic signed [WIDTH-1:0] inData,
  input  logic                    inLast,
  output logic                    outValid,
  input  logic                    outReady,
  output logic signed [WIDTH-1:0] outData,
  output logic                    outOverflow,
  output logic [COUNT_WIDTH-1:0]  outCount
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  acc_state_t                    r_state;
  logic signed [WIDTH-1:0]       r_acc;
  logic                          r_ovf;
  logic [COUNT_WIDTH-1:0]        r_cnt;
  logic                          r_first;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic signed [WIDTH-1:0]       r_out_data;
  logic                          r_out_ovf;
  logic [COUNT_WIDTH-1:0]        r_out_cnt;

  logic signed [WIDTH-1:0]       w_sum;
  logic                          w_sat;
  logic signed [WIDTH-1:0]       w_acc_next;
  logic                          w_ovf_next;
  logic [COUNT_WIDTH-1:0]        w_cnt_next;
  logic                          w_accept;

  sat_add16 #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (inData),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  assign w_accept = inValid && (r_state == ACCUM);

  // Post-beat values; the first term of a frame loads directly.
  always_comb begin
    w_acc_next = w_sum;
    w_ovf_next = r_ovf | w_sat;
    w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    if (r_first) begin
      w_acc_next = inData;
      w_ovf_next = 1'b0;
      w_cnt_next = CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_cnt   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (clear) begin
            // Any beat offered alongside clear is dropped.
            r_first <= 1'b1;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_cnt   <= w_cnt_next;
            r_first <= 1'b0;
            if (inLast) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_acc_next;
              r_out_ovf   <= w_ovf_next;
              r_out_cnt   <= w_cnt_next;
            end
          end
        end
        HOLD: begin
          if (outReady) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_first     <= 1'b1;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign inReady     = r_in_ready;
  assign outValid    = r_out_valid;
  assign outData     = r_out_data;
  assign outOverflow = r_out_ovf;
  assign outCount    = r_out_cnt;

endmodule : accumulator_x16

// File: tb/tb_accumulator_x16.sv
module tb_accumulator_x16;

  logic               clk;
  logic               reset;
  logic               clear;
  logic               inValid;
  logic               inReady;
  logic signed [15:0] inData;
  logic               inLast;
  logic               outValid;
  logic               outReady;
  logic signed [15:0] outData;
  logic               outOverflow;
  logic [7:0]         outCount;

  int tests  = 0;
  int failed = 0;

  accumulator_x16 #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .inValid     (inValid),
    .inReady     (inReady),
    .inData      (inData),
    .inLast      (inLast),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outOverflow (outOverflow),
    .outCount    (outCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][15:0]  terms;
    logic [15:0]       exp_data;
    logic [7:0]        exp_cnt;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input bit last);
    inValid = 1'b1;
    inData  = 16'(d);
    inLast  = last;
    step();
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int d, input int c, input bit o);
    check({tag, " outValid"},    {31'd0, outValid},    32'd1);
    check({tag, " outData"},     {16'd0, outData},     {16'd0, 16'(d)});
    check({tag, " outCount"},    {24'd0, outCount},    {24'd0, 8'(c)});
    check({tag, " outOverflow"}, {31'd0, outOverflow}, {31'd0, o});
  endtask

  task automatic set_vec(input int i, input int n, input int t0, input int t1, input int t2,
                         input int ed, input int ec, input bit eo);
    vecs[i].n        = 3'(n);
    vecs[i].terms[0] = 16'(t0);
    vecs[i].terms[1] = 16'(t1);
    vecs[i].terms[2] = 16'(t2);
    vecs[i].terms[3] = 16'd0;
    vecs[i].exp_data = 16'(ed);
    vecs[i].exp_cnt  = 8'(ec);
    vecs[i].exp_ovf  = eo;
  endtask

  // Reference model state: frame arithmetic on plain integers.
  int m_sum, m_cnt;
  bit m_ovf, m_first, m_hold;
  int m_rdata, m_rcnt;
  bit m_rovf;

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_ovf = 0; m_first = 1; m_hold = 0;
    m_rdata = 0; m_rcnt = 0; m_rovf = 0;
  endtask

  // Advances the model by one edge using the inputs currently driven.
  task automatic model_edge();
    int t;
    if (reset) begin
      model_reset();
    end else if (!m_hold) begin
      if (clear) begin
        m_first = 1; m_sum = 0; m_cnt = 0; m_ovf = 0;
      end else if (inValid) begin
        if (m_first) begin
          m_sum = int'(inData); m_ovf = 0; m_cnt = 1; m_first = 0;
        end else begin
          t = m_sum + int'(inData);
          if (t > 32767) begin t = 32767; m_ovf = 1; end
          else if (t < -32768) begin t = -32768; m_ovf = 1; end
          m_sum = t;
          m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
        if (inLast) begin
          m_hold = 1; m_rdata = m_sum; m_rcnt = m_cnt; m_rovf = m_ovf;
        end
      end
    end else if (outReady) begin
      m_hold = 0; m_first = 1; m_sum = 0; m_cnt = 0; m_ovf = 0;
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; inValid = 1'b0; inData = '0; inLast = 1'b0; outReady = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset outValid",    {31'd0, outValid},    32'd0);
    check("reset inReady",     {31'd0, inReady},     32'd1);
    check("reset outData",     {16'd0, outData},     32'd0);
    check("reset outCount",    {24'd0, outCount},    32'd0);
    check("reset outOverflow", {31'd0, outOverflow}, 32'd0);

    // Table-driven frames, each followed by one accepted result cycle.
    set_vec(0, 3, 3, 4, -2, 5, 3, 0);
    set_vec(1, 3, 'h7000, 'h2000, -'h1000, 'h6FFF, 3, 1);
    set_vec(2, 2, 'h8001, -5, 0, 'h8000, 2, 1);
    set_vec(3, 1, -7, 0, 0, 'hFFF9, 1, 0);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++)
        beat(int'($signed(vecs[i].terms[j])), j == int'(vecs[i].n) - 1);
      check("vec outValid",    {31'd0, outValid},    32'd1);
      check("vec inReady",     {31'd0, inReady},     32'd0);
      check("vec outData",     {16'd0, outData},     {16'd0, vecs[i].exp_data});
      check("vec outCount",    {24'd0, outCount},    {24'd0, vecs[i].exp_cnt});
      check("vec outOverflow", {31'd0, outOverflow}, {31'd0, vecs[i].exp_ovf});
      step();
      check("vec valid one cycle", {31'd0, outValid}, 32'd0);
      check("vec ready again",     {31'd0, inReady},  32'd1);
    end

    // Backpressure: result held, no beats consumed.
    outReady = 1'b0;
    beat(1, 0);
    beat(2, 1);
    for (int k = 0; k < 5; k++) begin
      inValid = 1'b1; inData = 16'sd100; inLast = 1'b1;
      step();
      check("hold inReady", {31'd0, inReady}, 32'd0);
      check_result("hold", 3, 2, 0);
    end
    inValid = 1'b0; inLast = 1'b0; outReady = 1'b1;
    step();
    check("hold released", {31'd0, outValid}, 32'd0);
    beat(5, 1);
    check_result("after hold", 5, 1, 0);
    step();

    // Clear drops the partial frame and the beat offered with it.
    beat(10, 0);
    beat(20, 0);
    clear = 1'b1; inValid = 1'b1; inData = 16'sd99; inLast = 1'b1;
    step();
    clear = 1'b0; inValid = 1'b0; inLast = 1'b0;
    check("clear inReady",  {31'd0, inReady},  32'd1);
    check("clear outValid", {31'd0, outValid}, 32'd0);
    outReady = 1'b0;
    beat(1, 1);
    check_result("after clear", 1, 1, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_result("clear in hold", 1, 1, 0);
    outReady = 1'b1;
    step();

    // Term counter saturates at 255.
    for (int k = 0; k < 300; k++) beat(0, k == 299);
    check_result("long frame", 0, 255, 0);
    step();

    // Reset mid-frame.
    beat(5, 0);
    beat(6, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset outValid", {31'd0, outValid}, 32'd0);
    check("midreset inReady",  {31'd0, inReady},  32'd1);
    beat(9, 1);
    check_result("after reset", 9, 1, 0);
    step();

    // Randomized traffic against the reference model.
    reset = 1'b1;
    model_edge();
    step();
    reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      inLast   = ($urandom_range(0, 5) == 0);
      outReady = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) inData = 16'($urandom_range(0, 65535));
      else inData = 16'(int'($urandom_range(0, 400)) - 200);
      model_edge();
      step();
      check("rnd outValid",    {31'd0, outValid},    {31'd0, m_hold});
      check("rnd inReady",     {31'd0, inReady},     {31'd0, !m_hold});
      check("rnd outData",     {16'd0, outData},     {16'd0, 16'(m_rdata)});
      check("rnd outCount",    {24'd0, outCount},    {24'd0, 8'(m_rcnt)});
      check("rnd outOverflow", {31'd0, outOverflow}, {31'd0, m_rovf});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_accumulator_x16
